// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Grants one command at a time, runs SETUP/ACCESS and bounds ACCESS with a PREADY timeout.
module apb_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                     pclk,
   input  logic                     presetn,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     psel,
   output logic                     penable,
   output logic                     pwrite,
   output logic [ADDR_W-1:0]        paddr,
   output logic [DATA_W-1:0]        pwdata,
   input  logic [DATA_W-1:0]        prdata,
   input  logic                     pready,
   input  logic                     pslverr
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_t;

   state_t              state_reg, state_next;
   logic [IDX_W-1:0]    ptr_reg, ptr_next;
   logic [IDX_W-1:0]    gnt_reg, gnt_next;
   logic                pwrite_reg, pwrite_next;
   logic [ADDR_W-1:0]   paddr_reg, paddr_next;
   logic [DATA_W-1:0]   pwdata_reg, pwdata_next;
   logic [DATA_W-1:0]   rd_data_reg, rd_data_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;

   logic [ADDR_W-1:0]   addr_arr  [NREQ];
   logic [DATA_W-1:0]   wdata_arr [NREQ];
   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    cand;
   logic                timeout_hit;
   logic                complete;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
         assign done[gi]      = complete && (gnt_reg == IDX_W'(gi));
      end
   endgenerate

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end else begin : g_timeout
         assign timeout_hit = (state_reg == ST_ACCESS) && !pready && (cnt_reg == CNT_LAST);
      end
   endgenerate

   // Search downwards so the candidate closest to ptr is the last (winning) assignment.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_reg) + k) % NREQ);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      gnt_next     = gnt_reg;
      pwrite_next  = pwrite_reg;
      paddr_next   = paddr_reg;
      pwdata_next  = pwdata_reg;
      rd_data_next = rd_data_reg;
      cnt_next     = cnt_reg;
      psel         = 1'b0;
      penable      = 1'b0;
      complete     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (win_found) begin
               state_next  = ST_SETUP;
               gnt_next    = win_idx;
               ptr_next    = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               pwrite_next = req_write[win_idx];
               paddr_next  = addr_arr[win_idx];
               pwdata_next = req_write[win_idx] ? wdata_arr[win_idx] : '0;
            end
         end
         ST_SETUP: begin
            psel       = 1'b1;
            state_next = ST_ACCESS;
            cnt_next   = '0;
         end
         ST_ACCESS: begin
            psel     = 1'b1;
            penable  = 1'b1;
            complete = pready || timeout_hit;
            if (complete) begin
               state_next = ST_IDLE;
               if (pready && !pwrite_reg)
                  rd_data_next = prdata;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // A timeout that coincides with pready is an ordinary pready completion.
   assign err     = complete && ((pready && pslverr) || timeout_hit);
   assign pwrite  = pwrite_reg;
   assign paddr   = paddr_reg;
   assign pwdata  = pwdata_reg;
   assign rd_data = rd_data_reg;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= '0;
         gnt_reg     <= '0;
         pwrite_reg  <= 1'b0;
         paddr_reg   <= '0;
         pwdata_reg  <= '0;
         rd_data_reg <= '0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         gnt_reg     <= gnt_next;
         pwrite_reg  <= pwrite_next;
         paddr_reg   <= paddr_next;
         pwdata_reg  <= pwdata_next;
         rd_data_reg <= rd_data_next;
         cnt_reg     <= cnt_next;
      end
   end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized bench for apb_rr_arbiter against a transaction-level round-robin model.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_apb_rr_arbiter;

   localparam int NREQ    = 4;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   logic                   pclk = 1'b0;
   logic                   presetn = 1'b0;
   logic [NREQ-1:0]        req = '0;
   logic [NREQ-1:0]        req_write = '0;
   logic [NREQ*ADDR_W-1:0] req_addr = '0;
   logic [NREQ*DATA_W-1:0] req_wdata = '0;
   logic [NREQ-1:0]        done;
   logic                   err;
   logic [DATA_W-1:0]      rd_data;
   logic                   psel, penable, pwrite;
   logic [ADDR_W-1:0]      paddr;
   logic [DATA_W-1:0]      pwdata;
   logic [DATA_W-1:0]      prdata = '0;
   logic                   pready = 1'b0;
   logic                   pslverr = 1'b0;

   always #5 pclk = ~pclk;

   apb_rr_arbiter #(
      .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .err(err), .rd_data(rd_data),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   int num_checks = 0;
   int num_fail   = 0;

   // Requester-side command table and the model's view of the arbiter.
   bit               cmd_valid [NREQ];
   bit               cmd_write [NREQ];
   bit               cmd_drop  [NREQ];
   logic [ADDR_W-1:0] cmd_addr  [NREQ];
   logic [DATA_W-1:0] cmd_wdata [NREQ];
   bit               req_off;
   int               model_ptr;
   logic [DATA_W-1:0] exp_rd;
   logic [ADDR_W-1:0] exp_paddr;
   logic [DATA_W-1:0] exp_pwdata;
   bit               exp_pwrite;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < NREQ; i++) begin
         req[i]       = cmd_valid[i] && !cmd_drop[i] && !req_off;
         req_write[i] = cmd_write[i];
         req_addr[i*ADDR_W +: ADDR_W]  = cmd_addr[i];
         req_wdata[i*DATA_W +: DATA_W] = cmd_wdata[i];
      end
   endtask

   task automatic load_cmd(input int i, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      cmd_valid[i] = 1'b1;
      cmd_write[i] = wr;
      cmd_addr[i]  = a;
      cmd_wdata[i] = d;
      cmd_drop[i]  = 1'b0;
   endtask

   task automatic model_reset();
      model_ptr  = 0;
      exp_rd     = '0;
      exp_paddr  = '0;
      exp_pwdata = '0;
      exp_pwrite = 1'b0;
   endtask

   function automatic int pick_winner();
      for (int k = 0; k < NREQ; k++)
         if (req[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
      return -1;
   endfunction

   task automatic check_idle(input string where);
      check_val({where, "_psel"},    32'(psel),    32'd0);
      check_val({where, "_penable"}, 32'(penable), 32'd0);
      check_val({where, "_done"},    32'(done),    32'd0);
      check_val({where, "_paddr"},   32'(paddr),   32'(exp_paddr));
      check_val({where, "_pwdata"},  32'(pwdata),  32'(exp_pwdata));
      check_val({where, "_pwrite"},  32'(pwrite),  32'(exp_pwrite));
      check_val({where, "_rd_data"}, 32'(rd_data), 32'(exp_rd));
   endtask

   task automatic idle_step();
      @(negedge pclk);
      drive_req();
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = DATA_W'($urandom);
      #1;
      check_idle("idle");
   endtask

   task automatic apply_reset();
      @(negedge pclk);
      presetn = 1'b0;
      req_off = 1'b1;
      drive_req();
      @(negedge pclk);
      presetn = 1'b1;
      #1;
      model_reset();
      check_idle("reset");
      req_off = 1'b0;
   endtask

   // Runs one grant from the current IDLE cycle: w = ACCESS cycles with pready low,
   // rst_at = ACCESS cycle in which presetn is pulled low (-1 for none).
   task automatic do_transfer(input int w, input bit err_in, input logic [DATA_W-1:0] rdat,
                              input int rst_at);
      int g;
      int j_end;
      bit to;
      g = pick_winner();
      if (g < 0) return;
      model_ptr  = (g + 1) % NREQ;
      exp_pwrite = cmd_write[g];
      exp_paddr  = cmd_addr[g];
      exp_pwdata = cmd_write[g] ? cmd_wdata[g] : '0;
      to    = (w >= TIMEOUT);
      j_end = to ? TIMEOUT - 1 : w;

      @(negedge pclk);
      if ($urandom_range(0, 3) == 0) cmd_drop[g] = 1'b1;
      drive_req();
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      #1;
      check_val("setup_psel",    32'(psel),    32'd1);
      check_val("setup_penable", 32'(penable), 32'd0);
      check_val("setup_done",    32'(done),    32'd0);
      check_val("setup_paddr",   32'(paddr),   32'(exp_paddr));
      check_val("setup_pwdata",  32'(pwdata),  32'(exp_pwdata));
      check_val("setup_pwrite",  32'(pwrite),  32'(exp_pwrite));

      for (int j = 0; j <= j_end; j++) begin
         @(negedge pclk);
         pready  = (j >= w);
         pslverr = (j >= w) ? err_in : 1'($urandom);
         prdata  = (j >= w) ? rdat : DATA_W'($urandom);
         if (j == rst_at) presetn = 1'b0;
         #1;
         check_val("access_psel",    32'(psel),    32'd1);
         check_val("access_penable", 32'(penable), 32'd1);
         check_val("access_paddr",   32'(paddr),   32'(exp_paddr));
         check_val("access_pwdata",  32'(pwdata),  32'(exp_pwdata));
         if (j == rst_at) begin
            check_val("rst_cycle_done", 32'(done), 32'd0);
            @(negedge pclk);
            presetn = 1'b1;
            req_off = 1'b1;
            drive_req();
            #1;
            model_reset();
            check_idle("after_rst");
            req_off = 1'b0;
            cmd_drop[g] = 1'b0;
            $display("xfer req%0d %s addr=0x%02h aborted by reset in ACCESS cycle %0d",
                     g, exp_pwrite ? "WR" : "RD", exp_paddr, j);
            return;
         end
         if (j < j_end) begin
            check_val("access_done", 32'(done), 32'd0);
         end else begin
            check_val("done_onehot", 32'(done), 32'(1 << g));
            check_val("done_err",    32'(err),  32'(to ? 1'b1 : err_in));
            if (!to && !exp_pwrite) exp_rd = rdat;
         end
      end
      cmd_valid[g] = 1'b0;
      cmd_drop[g]  = 1'b0;
      $display("xfer req%0d %s addr=0x%02h wait=%0d %s err=%0d",
               g, exp_pwrite ? "WR" : "RD", exp_paddr, w, to ? "timeout" : "ready",
               to ? 1 : int'(err_in));
   endtask

   initial begin
      int w;
      int rst_at;
      for (int i = 0; i < NREQ; i++) begin
         cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_drop[i] = 1'b0;
         cmd_addr[i] = '0; cmd_wdata[i] = '0;
      end
      req_off = 1'b0;
      model_reset();
      drive_req();

      repeat (3) @(negedge pclk);
      #1;
      check_idle("por");
      @(negedge pclk);
      presetn = 1'b1;

      // Single write with zero wait states.
      load_cmd(0, 1'b1, 8'h12, 8'hA5);
      idle_step();
      do_transfer(0, 1'b0, 8'h00, -1);

      // Read with two wait states; rd_data checked in the following idle cycle.
      load_cmd(2, 1'b0, 8'h40, 8'h77);
      idle_step();
      do_transfer(2, 1'b0, 8'h3C, -1);

      // Round robin from a fresh pointer with every requester always asking.
      apply_reset();
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < NREQ; i++)
            if (!cmd_valid[i]) load_cmd(i, 1'b1, ADDR_W'(8'h80 + i), DATA_W'(8'h10 * (i + 1)));
         idle_step();
         do_transfer(0, 1'b0, 8'h00, -1);
      end
      for (int i = 0; i < NREQ; i++) cmd_valid[i] = 1'b0;

      // Stuck pready: timeout after TIMEOUT ACCESS cycles, rd_data untouched.
      load_cmd(1, 1'b0, 8'h55, 8'h00);
      idle_step();
      do_transfer(TIMEOUT + 10, 1'b0, 8'hEE, -1);
      // Last cycle before the timeout: pready wins.
      load_cmd(1, 1'b0, 8'h56, 8'h00);
      idle_step();
      do_transfer(TIMEOUT - 1, 1'b0, 8'h9B, -1);

      // Slave error with pready.
      load_cmd(3, 1'b1, 8'h66, 8'h5A);
      idle_step();
      do_transfer(0, 1'b1, 8'h00, -1);

      // Reset during a wait state, then requester 0 must win first.
      load_cmd(1, 1'b0, 8'h21, 8'h00);
      idle_step();
      do_transfer(10, 1'b0, 8'h00, 4);
      for (int i = 0; i < NREQ; i++) load_cmd(i, 1'b0, ADDR_W'(8'hC0 + i), 8'h00);
      idle_step();
      check_val("post_rst_winner_req0", 32'(pick_winner()), 32'd0);
      do_transfer(0, 1'b0, 8'h44, -1);

      // Random traffic.
      repeat (250) begin
         for (int i = 0; i < NREQ; i++)
            if (!cmd_valid[i] && $urandom_range(0, 2) == 0)
               load_cmd(i, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
         idle_step();
         if (req != '0) begin
            case ($urandom_range(0, 9))
               0:       w = $urandom_range(TIMEOUT - 1, TIMEOUT + 3);
               1:       w = $urandom_range(4, 8);
               default: w = $urandom_range(0, 3);
            endcase
            rst_at = (w >= 3 && $urandom_range(0, 39) == 0) ? 1 : -1;
            do_transfer(w, 1'($urandom), DATA_W'($urandom), rst_at);
         end
      end

      idle_step();
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin arbiter and sequencer that shares one APB master port between NREQ local requesters. Each requester presents a command (read/write, address, write data) with a level request. The block grants one requester at a time, latches its command and drives the APB SETUP/ACCESS sequence. It then returns completion, error and read data, and enforces a PREADY timeout. It sits between the on-chip clients and the APB slave fabric.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting for pready; 0 disables the timeout
- pclk  in  1  clock, all logic on rising edge
- presetn  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester request level
- req_write  in  NREQ  per-requester direction, 1 = write
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data, same packing
- done  out  NREQ  one-hot completion strobe, combinational
- err  out  1  error qualifier, valid only while done is nonzero
- rd_data  out  DATA_W  registered read data of the last completed read
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

## Operation
- FSM states:
  - IDLE: psel=0, penable=0. If any req bit is set, arbitrate, latch the winner's index and command, and go to SETUP.
  - SETUP: psel=1, penable=0. Always go to ACCESS.
  - ACCESS: psel=1, penable=1. On pready or timeout, complete and go to IDLE. Otherwise stay.
- Arbitration:
  - Round-robin pointer ptr (register, reset 0). The search starts at index ptr and wraps modulo NREQ.
  - On grant to index g, ptr <= (g+1) mod NREQ.
  - With a single requester active, it is granted every transfer.
- Command latch:
  - pwrite, paddr and pwdata are registered from the granted requester at the IDLE->SETUP edge.
  - They are held constant through SETUP and ACCESS.
  - pwdata is 0 for reads.
  - In IDLE, paddr, pwdata and pwrite keep their last values. Only psel and penable return to 0.
- Completion cycle (ACCESS and (pready or timeout)):
  - done[g]=1 for exactly that cycle. All other done bits stay 0.
  - err = (pready & pslverr) | timeout.
- Requester rules:
  - Hold req and the command stable until done[i]. Drop req, or present a new command, at the edge after done[i].
  - Dropping req after grant does not abort the transfer. done still pulses.
- Read data: on a read completing with pready=1, rd_data <= prdata at that edge. Timeouts and writes leave rd_data unchanged.
- Timeout counter:
  - Cleared on entering ACCESS; increments each ACCESS cycle with pready=0.
  - Timeout is asserted when the counter equals TIMEOUT-1 and pready=0, giving exactly TIMEOUT ACCESS cycles.
  - With TIMEOUT=0, the block waits forever.
- Simultaneous pready and timeout: treated as a pready completion, with err = pslverr.
- Reset (presetn=0 at an edge, including mid-transfer):
  - State goes to IDLE and ptr to 0.
  - psel, penable, pwrite, paddr, pwdata, rd_data and the counter all go to 0.
  - No done is generated for the aborted transfer.

## Timing
- Grant latency: req seen in IDLE at cycle N gives SETUP at N+1 and ACCESS at N+2. The earliest done is at N+2 (pready already high).
- Minimum of 3 cycles per transfer (IDLE, SETUP, ACCESS). The mandatory IDLE cycle between transfers ensures a released req is never re-granted.
- Back-to-back sustained throughput is 1 transfer per 3 cycles with zero wait states.
- Wait states extend ACCESS one cycle per pready=0 cycle, up to TIMEOUT.
- done and err are combinational from state, pready and the counter. rd_data is valid from the cycle after done.

## Test plan
- Single write: req[0]=1, write, addr 0x12, data 0xA5, pready=1.
  - Expect psel rise at cycle N+1, penable at N+2, paddr=0x12, pwdata=0xA5.
  - Expect done=4'b0001 at N+2 with err=0.
- Read with 2 wait states: req[2] read, addr 0x40, pready low for 2 ACCESS cycles, prdata=0x3C.
  - Expect ACCESS to last 3 cycles and done=4'b0100 on the third.
  - Expect rd_data=0x3C on the following cycle.
- Round robin: all 4 req held, pready=1.
  - Expect grant order 0,1,2,3,0, one done every 3 cycles, and no starvation.
- Timeout and error: TIMEOUT=16, pready stuck 0.
  - Expect done with err=1 after 16 ACCESS cycles and rd_data unchanged.
  - Separate transfer with pready=1, pslverr=1: expect err=1.
- Reset mid-ACCESS: presetn=0 during a wait state.
  - Expect psel=penable=0 and paddr=pwdata=rd_data=0 at the next edge, with no done.
  - Expect ptr=0, so req[0] wins first after release.
